score_bcd_display_ctrl: RTL

Sequential score-to-display controller for the Whack-a-Mole score path. It accepts an 8-bit binary score and converts it to BCD (ones, tens, hundreds) with an iterative shift-add-3 (double-dabble) engine, one bit per clock. It holds the last converted result and time-multiplexes the three digits onto the 7-segment anodes. digit_value drives the existing 7-segment decoder.

---
 rtl/score_bcd_display_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/score_bcd_display_ctrl.sv
// score_bcd_display_ctrl: serial double-dabble score-to-BCD converter with a 3-digit 7-segment scan multiplexer
//   Parameter SCAN_DIV : clk cycles per digit refresh slot (>=2)
//   Ports: clk, rst_n (async active-low), score[7:0]/score_valid (request),
//          busy, done (pulse on display update), bcd_ones/bcd_tens/bcd_hundreds (latched result),
//          anode_n[3:0] (active-low digit enables, [3] unused), digit_value[3:0] (to segment decoder)
//   Optional macro LEADING_ZERO_BLANK_EN: blanks leading-zero tens/hundreds digits.
module score_bcd_display_ctrl #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] score,
    input  logic       score_valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_ones,
    output logic [3:0] bcd_tens,
    output logic [1:0] bcd_hundreds,
    output logic [3:0] anode_n,
    output logic [3:0] digit_value
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [7:0]    shreg;
    logic [7:0]    pend_val;
    logic          pend;
    logic [9:0]    acc;
    logic [2:0]    bitcnt;
    logic [3:0]    ones_a;
    logic [3:0]    tens_a;
    logic [9:0]    adj;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [1:0]    idx_n;
    logic          wrap;
    logic [3:0]    anode_d;
    logic [3:0]    digit_d;

    // add-3 correction before each shift; hundreds never reaches 5 for 8-bit input
    always_comb begin
        ones_a = (acc[3:0] >= 4'd5) ? acc[3:0] + 4'd3 : acc[3:0];
        tens_a = (acc[7:4] >= 4'd5) ? acc[7:4] + 4'd3 : acc[7:4];
        adj    = {acc[9:8], tens_a, ones_a};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            shreg        <= '0;
            pend_val     <= '0;
            pend         <= 1'b0;
            acc          <= '0;
            bitcnt       <= '0;
            bcd_ones     <= '0;
            bcd_tens     <= '0;
            bcd_hundreds <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (score_valid) begin
                        shreg  <= score;
                        acc    <= '0;
                        bitcnt <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc    <= {adj[8:0], shreg[7]};
                    shreg  <= {shreg[6:0], 1'b0};
                    bitcnt <= bitcnt + 3'd1;
                    if (bitcnt == 3'd7)
                        state <= DONE;
                    // requests during a conversion are held; the latest one wins
                    if (score_valid) begin
                        pend     <= 1'b1;
                        pend_val <= score;
                    end
                end
                DONE: begin
                    bcd_ones     <= acc[3:0];
                    bcd_tens     <= acc[7:4];
                    bcd_hundreds <= acc[9:8];
                    done         <= 1'b1;
                    pend         <= 1'b0;
                    acc          <= '0;
                    bitcnt       <= '0;
                    // a fresh request in this cycle overrides the held one
                    if (score_valid || pend) begin
                        shreg <= score_valid ? score : pend_val;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign wrap  = (scan_cnt == CW'(SCAN_DIV - 1));
    assign idx_n = wrap ? ((idx == 2'd2) ? 2'd0 : idx + 2'd1) : idx;

    // outputs are computed from the next index so they change on the same edge as it
    always_comb begin
        digit_d = (idx_n == 2'd0) ? bcd_ones : (idx_n == 2'd1) ? bcd_tens : {2'b00, bcd_hundreds};
`ifdef LEADING_ZERO_BLANK_EN
        anode_d = (idx_n == 2'd0) ? 4'b1110 :
                  (idx_n == 2'd1) ? ((bcd_hundreds == 2'd0 && bcd_tens == 4'd0) ? 4'b1111 : 4'b1101) :
                  ((bcd_hundreds == 2'd0) ? 4'b1111 : 4'b1011);
`else
        anode_d = (idx_n == 2'd0) ? 4'b1110 : (idx_n == 2'd1) ? 4'b1101 : 4'b1011;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt    <= '0;
            idx         <= '0;
            anode_n     <= 4'b1110;
            digit_value <= '0;
        end else begin
            scan_cnt    <= wrap ? '0 : scan_cnt + CW'(1);
            idx         <= idx_n;
            anode_n     <= anode_d;
            digit_value <= digit_d;
        end
    end
endmodule
